// File: rtl/mux32_rr_arbiter.sv
// rtl/mux32_rr_arbiter.sv - round-robin arbiter driving a shared 32:1 mux select
// Grants are held until release or until MAX_HOLD cycles expire while others wait.
module mux32_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] req,
  output logic [31:0] grant,
  output logic [4:0]  select,
  output logic        valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t      state_q, state_d;
  logic [4:0]  ptr_q, ptr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  select_q, select_d;
  logic [31:0] grant_q, grant_d;
  logic        valid_q, valid_d;

  logic [4:0]  next_ptr;
  logic [31:0] others;
  logic [5:0]  pick_idle, pick_rel, pick_to;
  logic        timeout;

  // Returns {found, index} of the first set bit scanning upward from p, wrapping at 31.
  function automatic logic [5:0] rr_pick(input logic [31:0] v, input logic [4:0] p);
    logic [5:0] r;
    logic [4:0] idx;
    r = '0;
    for (int i = 31; i >= 0; i--) begin
      idx = p + 5'(i);
      if (v[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  assign next_ptr  = select_q + 5'd1;
  assign others    = req & ~(32'd1 << select_q);
  assign pick_idle = rr_pick(req, ptr_q);
  assign pick_rel  = rr_pick(req, next_ptr);
  assign pick_to   = rr_pick(others, next_ptr);
  assign timeout   = (MAX_HOLD != 0) && (32'(cnt_q) >= MAX_HOLD);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    select_d = select_q;
    valid_d  = valid_q;
    case (state_q)
      IDLE: begin
        if (pick_idle[5]) begin
          state_d  = GRANT;
          select_d = pick_idle[4:0];
          cnt_d    = 8'd1;
          valid_d  = 1'b1;
        end
      end
      GRANT: begin
        if (!req[select_q]) begin
          ptr_d = next_ptr;
          if (pick_rel[5]) begin
            select_d = pick_rel[4:0];
            cnt_d    = 8'd1;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end else if (timeout) begin
          // With nobody else waiting the holder is simply re-granted, keeping outputs steady.
          ptr_d = next_ptr;
          cnt_d = 8'd1;
          if (pick_to[5]) select_d = pick_to[4:0];
        end else begin
          cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    grant_d = valid_d ? (32'd1 << select_d) : 32'd0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      select_q <= '0;
      grant_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      select_q <= select_d;
      grant_q  <= grant_d;
      valid_q  <= valid_d;
    end
  end

  assign grant  = grant_q;
  assign select = select_q;
  assign valid  = valid_q;

endmodule
